// File: rtl/mar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mar_pkg
// Description : Shared state encoding and default widths for the burst MAR.
// Revision    : 1.0 - initial release
// ============================================================================
package mar_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_NUM_SRC = 2;
    localparam int DEF_BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } mar_state_e;

endpackage : mar_pkg
`default_nettype wire

// File: rtl/mar_src_mux.sv
`default_nettype none
// ============================================================================
// Module      : mar_src_mux
// Description : Combinational priority select of a load address; the
//               highest-index source with its strobe set wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mar_src_mux
    import mar_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic [NUM_SRC-1:0]        ld_en,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0]         sel_addr,
    output logic                      any_ld
);

    // Ascending scan: a later (higher-index) hit overwrites earlier ones.
    always_comb begin
        sel_addr = '0;
        any_ld   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ld_en[i]) begin
                sel_addr = src_addr[i*ADDR_W +: ADDR_W];
                any_ld   = 1'b1;
            end
        end
    end

endmodule : mar_src_mux
`default_nettype wire

// File: rtl/mar_burst.sv
`default_nettype none
// ============================================================================
// Module      : mar_burst
// Description : Memory address register with multi-source load and an
//               incrementing burst engine (IDLE -> BURST -> DONE).
//               Define MAR_BOUND_CHECK_EN to abort bursts that would step
//               past ADDR_LIMIT and raise a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mar_burst
    import mar_pkg::*;
#(
    parameter int              ADDR_W     = DEF_ADDR_W,
    parameter int              NUM_SRC    = DEF_NUM_SRC,
    parameter int              BURST_W    = DEF_BURST_W,
    parameter longint unsigned ADDR_LIMIT = (64'd1 << ADDR_W) - 64'd1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        ld_en,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic                      burst_start,
    input  logic [BURST_W-1:0]        burst_len,
    input  logic                      mem_ack,
    output logic [ADDR_W-1:0]         addr_out,
    output logic                      mem_req,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // One extra bit so burst_len = all-ones still fits as a beat count.
    localparam int c_cnt_w = BURST_W + 1;

    if (ADDR_LIMIT > ((64'd1 << ADDR_W) - 64'd1)) begin : g_limit_chk
        $error("mar_burst: ADDR_LIMIT exceeds the address range");
    end

    mar_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [c_cnt_w-1:0]  beats_q, beats_d;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_any_ld;

    mar_src_mux #(
        .NUM_SRC (NUM_SRC),
        .ADDR_W  (ADDR_W)
    ) u_src_mux (
        .ld_en    (ld_en),
        .src_addr (src_addr),
        .sel_addr (w_sel_addr),
        .any_ld   (w_any_ld)
    );

`ifdef MAR_BOUND_CHECK_EN
    localparam logic [ADDR_W-1:0] c_limit = ADDR_W'(ADDR_LIMIT);

    logic err_q, err_d;
    logic w_over;

    // At or beyond the limit, the next increment would carry past it.
    assign w_over = (addr_q >= c_limit);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
`ifdef MAR_BOUND_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Load lands on the same edge as the burst capture, so the
                // first beat already sees the new address.
                if (w_any_ld) begin
                    addr_d = w_sel_addr;
                end
                if (burst_start) begin
                    beats_d = {1'b0, burst_len} + c_cnt_w'(1);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (mem_ack) begin
`ifdef MAR_BOUND_CHECK_EN
                    if (w_over) begin
                        err_d   = 1'b1;
                        beats_d = '0;
                        state_d = DONE;
                    end else
`endif
                    begin
                        addr_d  = addr_q + ADDR_W'(1);
                        beats_d = beats_q - c_cnt_w'(1);
                        if (beats_q == c_cnt_w'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

`ifdef MAR_BOUND_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign addr_out = addr_q;
    assign mem_req  = (state_q == BURST);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule : mar_burst
`default_nettype wire

// File: tb/tb_mar_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_mar_burst
// Description : Directed self-checking bench for mar_burst (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mar_burst;

    logic        clk;
    logic        rst;
    logic [1:0]  ld_en;
    logic [15:0] src_addr;
    logic        burst_start;
    logic [3:0]  burst_len;
    logic        mem_ack;
    logic [7:0]  addr_out;
    logic        mem_req;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;

    mar_burst dut (
        .clk         (clk),
        .rst         (rst),
        .ld_en       (ld_en),
        .src_addr    (src_addr),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .mem_ack     (mem_ack),
        .addr_out    (addr_out),
        .mem_req     (mem_req),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_en       = 2'b00;
        src_addr    = 16'h0000;
        burst_start = 1'b0;
        burst_len   = 4'd0;
        mem_ack     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if ({addr_out, mem_req, busy, done, err} !== {8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got addr=%h req=%b busy=%b done=%b err=%b, want 00/0/0/0/0",
                     addr_out, mem_req, busy, done, err);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({addr_out, busy} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got addr=%h busy=%b, want 00/0", addr_out, busy);
        end
    endtask

    task automatic test_priority();
        ld_en    = 2'b11;
        src_addr = {8'h40, 8'h10};
        tick();
        checks++;
        if (addr_out !== 8'h40) begin
            errors++;
            $display("FAIL prio_both: got %h want 40", addr_out);
        end
        ld_en = 2'b01;
        tick();
        checks++;
        if (addr_out !== 8'h10) begin
            errors++;
            $display("FAIL prio_src0: got %h want 10", addr_out);
        end
        ld_en    = 2'b00;
        src_addr = {8'h77, 8'h66};
        tick();
        checks++;
        if (addr_out !== 8'h10) begin
            errors++;
            $display("FAIL prio_hold: got %h want 10", addr_out);
        end
    endtask

    task automatic test_burst4();
        int beat;
        int busy_cnt;
        int done_cnt;
        ld_en    = 2'b01;
        src_addr = {8'h00, 8'h20};
        tick();
        ld_en       = 2'b00;
        burst_start = 1'b1;
        burst_len   = 4'd3;
        mem_ack     = 1'b1;
        tick();
        burst_start = 1'b0;
        beat     = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (mem_req) begin
                checks++;
                if (addr_out !== 8'(8'h20 + beat)) begin
                    errors++;
                    $display("FAIL burst4_beat%0d: got %h want %h", beat, addr_out, 8'(8'h20 + beat));
                end
                beat++;
            end
            if (done) begin
                checks++;
                if (addr_out !== 8'h24) begin
                    errors++;
                    $display("FAIL burst4_end_addr: got %h want 24", addr_out);
                end
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (beat != 4 || busy_cnt != 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL burst4_counts: got beats=%0d busy=%0d done=%0d want 4/5/1",
                     beat, busy_cnt, done_cnt);
        end
    endtask

    task automatic test_simul_load_burst();
        ld_en       = 2'b01;
        src_addr    = {8'hAA, 8'h05};
        burst_start = 1'b1;
        burst_len   = 4'd0;
        tick();
        ld_en       = 2'b00;
        burst_start = 1'b0;
        checks++;
        if ({addr_out, mem_req} !== {8'h05, 1'b1}) begin
            errors++;
            $display("FAIL simul_beat: got addr=%h req=%b want 05/1", addr_out, mem_req);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({addr_out, done, mem_req} !== {8'h06, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL simul_done: got addr=%h done=%b req=%b want 06/1/0", addr_out, done, mem_req);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        burst_start = 1'b1;
        burst_len   = 4'd0;
        tick();
        burst_start = 1'b0;
        mem_ack     = 1'b1;
        tick();
        // In DONE: a start here must be ignored, then taken in the next IDLE.
        mem_ack     = 1'b0;
        burst_start = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b want 1", done);
        end
        tick();
        checks++;
        if ({busy, addr_out} !== {1'b0, 8'h07}) begin
            errors++;
            $display("FAIL b2b_ignore_in_done: got busy=%b addr=%h want 0/07", busy, addr_out);
        end
        tick();
        burst_start = 1'b0;
        checks++;
        if ({mem_req, addr_out} !== {1'b1, 8'h07}) begin
            errors++;
            $display("FAIL b2b_turnaround: got req=%b addr=%h want 1/07", mem_req, addr_out);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        ld_en    = 2'b10;
        src_addr = {8'h30, 8'h00};
        tick();
        ld_en       = 2'b00;
        burst_start = 1'b1;
        burst_len   = 4'd1;
        tick();
        ld_en       = 2'b11;
        src_addr    = {8'hBB, 8'hAA};
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({addr_out, mem_req} !== {8'h30, 1'b1}) begin
                errors++;
                $display("FAIL stall_c%0d: got addr=%h req=%b want 30/1", c, addr_out, mem_req);
            end
            tick();
        end
        ld_en       = 2'b00;
        burst_start = 1'b0;
        mem_ack     = 1'b1;
        tick();
        checks++;
        if ({addr_out, mem_req} !== {8'h31, 1'b1}) begin
            errors++;
            $display("FAIL stall_beat2: got addr=%h req=%b want 31/1", addr_out, mem_req);
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({addr_out, done} !== {8'h32, 1'b1}) begin
            errors++;
            $display("FAIL stall_end: got addr=%h done=%b want 32/1", addr_out, done);
        end
        tick();
    endtask

    task automatic test_wrap_bound();
        logic [7:0] exp_seq [4];
        int beat;
        int done_cnt;
        exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ld_en    = 2'b01;
        src_addr = {8'h00, 8'hFE};
        tick();
        ld_en       = 2'b00;
        burst_start = 1'b1;
        burst_len   = 4'd3;
        mem_ack     = 1'b1;
        tick();
        burst_start = 1'b0;
        beat     = 0;
        done_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            if (mem_req && beat < 4) begin
                checks++;
                if (addr_out !== exp_seq[beat]) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: got %h want %h", beat, addr_out, exp_seq[beat]);
                end
                beat++;
            end
            if (done) begin
                done_cnt++;
                checks++;
`ifdef MAR_BOUND_CHECK_EN
                if ({addr_out, err} !== {8'hFF, 1'b1}) begin
                    errors++;
                    $display("FAIL bound_abort: got addr=%h err=%b want FF/1", addr_out, err);
                end
`else
                if ({addr_out, err} !== {8'h02, 1'b0}) begin
                    errors++;
                    $display("FAIL wrap_end: got addr=%h err=%b want 02/0", addr_out, err);
                end
`endif
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
`ifdef MAR_BOUND_CHECK_EN
        if (beat != 2 || done_cnt != 1 || err !== 1'b1) begin
            errors++;
            $display("FAIL bound_counts: got beats=%0d done=%0d err=%b want 2/1/1", beat, done_cnt, err);
        end
`else
        if (beat != 4 || done_cnt != 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_counts: got beats=%0d done=%0d err=%b want 4/1/0", beat, done_cnt, err);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int done_cnt;
        ld_en    = 2'b01;
        src_addr = {8'h00, 8'h50};
        tick();
        ld_en       = 2'b00;
        burst_start = 1'b1;
        burst_len   = 4'd3;
        mem_ack     = 1'b1;
        tick();
        burst_start = 1'b0;
        tick();
        tick();
        checks++;
        if ({addr_out, mem_req} !== {8'h52, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_pre: got addr=%h req=%b want 52/1", addr_out, mem_req);
        end
        // Assert reset between edges: the clear must not wait for clk.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({addr_out, mem_req, busy, done, err} !== {8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL rstmid_async: got addr=%h req=%b busy=%b done=%b err=%b want 00/0/0/0/0",
                     addr_out, mem_req, busy, done, err);
        end
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        mem_ack = 1'b0;
        checks++;
        if (done_cnt != 0 || addr_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_after: got activity=%0d addr=%h want 0/00", done_cnt, addr_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_priority();
        test_burst4();
        test_simul_load_burst();
        test_back_to_back();
        test_stall();
        test_wrap_bound();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule : tb_mar_burst
`default_nettype wire

// File: doc/mar_burst.md
MAR_BURST -- requirements
Module: mar_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the width of the address register and of every source.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning the number of address load sources.
REQ-003 SHALL have parameter BURST_W, default 4, meaning the width of the beat-count field.
REQ-004 SHALL have parameter ADDR_LIMIT, default 2**ADDR_W-1, meaning the highest legal address.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-007 SHALL have port ld_en, input, NUM_SRC, one load strobe per source.
REQ-008 SHALL have port src_addr, input, NUM_SRC*ADDR_W, the packed source addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port burst_start, input, 1, which requests a burst from the current address.
REQ-010 SHALL have port burst_len, input, BURST_W, giving the beat count minus one; it is sampled with burst_start.
REQ-011 SHALL have port mem_ack, input, 1, the memory beat acknowledge.
REQ-012 SHALL have port addr_out, output, ADDR_W, the registered address.
REQ-013 SHALL have port mem_req, output, 1, asserted while a beat is outstanding.
REQ-014 SHALL have port busy, output, 1, high in states BURST and DONE.
REQ-015 SHALL have port done, output, 1, a one-cycle burst-complete pulse.
REQ-016 SHALL have port err, output, 1, a sticky bound-violation flag.

Function
REQ-017 SHALL implement a state machine with states IDLE, BURST and DONE; it leaves reset in IDLE.
REQ-018 SHALL, in IDLE, load addr_out on the next edge from the highest-index source whose ld_en bit is set; if no bit is set, addr_out holds.
REQ-019 SHALL, in IDLE on burst_start, capture a remaining-beat count of burst_len+1 and go to BURST; burst_len=0 gives one beat.
REQ-020 SHALL, when ld_en and burst_start occur in the same IDLE cycle, apply the load on that edge so the burst's first beat uses the new address.
REQ-021 SHALL drive mem_req=1 for the whole of BURST; addr_out is valid for the current beat.
REQ-022 SHALL, on each mem_ack in BURST, increment addr_out by 1 modulo 2**ADDR_W and decrement the beat count; a mem_ack in IDLE or DONE is ignored.
REQ-023 SHALL go to DONE on the acknowledge of the final beat; addr_out is then start+beats, the next free address.
REQ-024 SHALL stay in DONE for exactly one cycle with done=1 and mem_req=0, then return to IDLE.
REQ-025 SHALL ignore ld_en and burst_start in BURST and DONE, with no queuing.
REQ-026 SHALL give a new burst_start a zero-cycle turnaround: it is accepted in the first IDLE cycle after DONE.

Reset
REQ-027 SHALL, while rst=1 and regardless of clk, force state IDLE, addr_out=0, beat count=0, mem_req=0, busy=0, done=0 and err=0.
REQ-028 SHALL, on reset in the middle of a burst, abandon the burst with no done pulse.

Configuration
REQ-029 SHALL, with MAR_BOUND_CHECK_EN defined, abort the burst when an increment would carry addr_out above ADDR_LIMIT: addr_out holds, err sets and stays set until reset, and the block goes to DONE with done=1.
REQ-030 SHALL, with MAR_BOUND_CHECK_EN undefined, wrap addr_out modulo 2**ADDR_W, tie err to 0, and ignore ADDR_LIMIT.

Structure
REQ-031 SHALL place the state enum (IDLE/BURST/DONE) and the default widths in shared package mar_pkg.
REQ-032 SHALL put the priority source selection in sub-module mar_src_mux, which is combinational and parameterised by NUM_SRC and ADDR_W.

Verification
REQ-033 SHALL cover priority: ld_en=2'b11, src_addr={8'h40,8'h10} -> addr_out=8'h40 on the next cycle.
REQ-034 SHALL cover a four-beat burst: load 8'h20, burst_len=3, mem_ack on every cycle -> addr_out steps 20,21,22,23, ends at 8'h24, done pulses once, and busy spans 5 cycles.
REQ-035 SHALL cover simultaneous load and burst: ld_en[0] with 8'h05 plus burst_start with burst_len=0 -> one beat at 8'h05, then addr_out=8'h06.
REQ-036 SHALL cover wrap and bound: start 8'hFE, burst_len=3 -> undefined macro gives FE,FF,00,01 with err=0; defined macro with ADDR_LIMIT=8'hFF gives an abort at FF with err=1 and done=1.
REQ-037 SHALL cover reset mid-burst: rst pulsed after the second ack -> addr_out=0, state IDLE, mem_req=0, no done pulse.
REQ-038 SHALL cover stalls: mem_ack held low for 3 cycles in BURST -> addr_out and mem_req stable and no beat lost; ld_en pulsed during BURST -> no effect.
